// File: rtl/muldiv_pkg.sv
// Shared constants, opcodes and FSM state type for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply (i_div=0) or restoring divide (i_div=1) on a 64-bit accumulator.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]     w_sum;
  logic [2*XLEN:0]   w_shl;
  logic [XLEN:0]     w_diff;

  always_comb begin
    w_sum  = '0;
    w_shl  = '0;
    w_diff = '0;
    o_acc  = i_acc;
    if (!i_div) begin
      // multiplier LSB sits in acc[0]; carry out of the add becomes the new MSB
      w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opb} : '0);
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end else begin
      // acc holds {remainder, quotient}; the shifted remainder needs XLEN+1 bits
      w_shl  = {i_acc, 1'b0};
      w_diff = w_shl[2*XLEN:XLEN] - {1'b0, i_opb};
      if (!w_diff[XLEN])
        o_acc = {w_diff[XLEN-1:0], w_shl[XLEN-1:1], 1'b1};
      else
        o_acc = w_shl[2*XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M MUL/DIV/REM controller: 32-iteration FSM with RISC-V sign and corner-case rules.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_data1,
  input  logic [XLEN-1:0] i_data2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_stall
);

  state_t              r_state, w_next;
  logic [5:0]          r_cnt;
  logic [2:0]          r_funct3;
  logic                r_neg;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;
  logic [XLEN-1:0]     r_result;

  logic                w_sgn1_en, w_sgn2_en, w_sign1, w_sign2, w_neg, w_is_div;
  logic [XLEN-1:0]     w_mag1, w_mag2, w_special_res, w_fix_res, w_quo, w_rem;
  logic                w_special, w_accept;
  logic [2*XLEN-1:0]   w_step, w_prod;

  always_comb begin
    w_sgn1_en = 1'b0;
    w_sgn2_en = 1'b0;
    case (i_funct3)
      MD_MULH:   begin w_sgn1_en = 1'b1; w_sgn2_en = 1'b1; end
      MD_MULHSU: w_sgn1_en = 1'b1;
      MD_DIV:    begin w_sgn1_en = 1'b1; w_sgn2_en = 1'b1; end
      MD_REM:    begin w_sgn1_en = 1'b1; w_sgn2_en = 1'b1; end
      MD_MUL, MD_MULHU, MD_DIVU, MD_REMU: ;
      default: ;
    endcase
  end

  assign w_sign1  = w_sgn1_en & i_data1[XLEN-1];
  assign w_sign2  = w_sgn2_en & i_data2[XLEN-1];
  assign w_mag1   = w_sign1 ? -i_data1 : i_data1;
  assign w_mag2   = w_sign2 ? -i_data2 : i_data2;
  assign w_is_div = i_funct3[2];
  // remainder follows the dividend sign; product and quotient follow sign1^sign2
  assign w_neg    = (i_funct3 == MD_REM) ? w_sign1 : (w_sign1 ^ w_sign2);
  assign w_accept = (r_state == S_IDLE) & i_start & ~i_flush;

  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
    if (w_is_div && i_data2 == '0) begin
      w_special     = 1'b1;
      w_special_res = i_funct3[1] ? i_data1 : '1;
    end else if ((i_funct3 == MD_DIV || i_funct3 == MD_REM) &&
                 i_data1 == {1'b1, {(XLEN-1){1'b0}}} && i_data2 == '1) begin
      w_special     = 1'b1;
      w_special_res = i_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  muldiv_step u_step (
    .i_div (r_funct3[2]),
    .i_acc (r_acc),
    .i_opb (r_opb),
    .o_acc (w_step)
  );

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_funct3)
      MD_MUL:                       w_fix_res = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_fix_res = w_quo;
      MD_REM, MD_REMU:              w_fix_res = w_rem;
      default:                      w_fix_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (i_flush)                      w_next = S_IDLE;
        else if (r_cnt == 6'(ITERS - 1))  w_next = S_FIX;
      end
      S_FIX:  w_next = i_flush ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_funct3 <= i_funct3;
          r_neg    <= w_neg;
          r_cnt    <= '0;
          r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
          r_opb    <= w_is_div ? w_mag2 : w_mag1;
          if (w_special) r_result <= w_special_res;
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: if (!i_flush) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_stall  = w_accept | (o_busy & ~o_done);

endmodule
